// File: rtl/ddr3_pkg.sv
// Shared DDR3 responder definitions: command pin encodings, error codes and
// burst geometry used by the responder and its delay lines.
package ddr3_pkg;

   // Encoded as {RAS_N, CAS_N, WE_N}
   typedef enum logic [2:0] {
      CMD_MRS = 3'b000,
      CMD_REF = 3'b001,
      CMD_PRE = 3'b010,
      CMD_ACT = 3'b011,
      CMD_WR  = 3'b100,
      CMD_RD  = 3'b101,
      CMD_ZQ  = 3'b110,
      CMD_NOP = 3'b111
   } cmd_e;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_ACT_OPEN = 3'd1,
      ERR_CLOSED   = 3'd2,
      ERR_REF_OPEN = 3'd3,
      ERR_TCCD     = 3'd4,
      ERR_MRS_OPEN = 3'd5
   } err_e;

   localparam int unsigned COL_BITS = 7;
   localparam logic [2:0]  TCCD     = 3'd4;

   function automatic int unsigned pair_width(input int unsigned dq_bits);
      return 2 * dq_bits;
   endfunction

endpackage

// File: rtl/ddr3_delay_line.sv
// Fixed-depth shift register carrying burst descriptors from the command
// edge to the start of the data phase; reset flushes every stage.
module ddr3_delay_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/ddr3_cmd_responder.sv
// Memory-side DDR3 command responder: decodes commands, tracks open rows,
// stores BL8 write bursts and replays read bursts after CL as SDR beat pairs.
module ddr3_cmd_responder
   import ddr3_pkg::*;
#(
   parameter int unsigned CL       = 6,
   parameter int unsigned CWL      = 5,
   parameter int unsigned DQ_BITS  = 16,
   parameter int unsigned DM_BITS  = 2,
   parameter int unsigned ROW_KEEP = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           CKE,
   input  logic                           CS_N,
   input  logic                           RAS_N,
   input  logic                           CAS_N,
   input  logic                           WE_N,
   input  logic [2:0]                     BA,
   input  logic [13:0]                    ADDR,
   input  logic [pair_width(DQ_BITS)-1:0] wdata,
   input  logic [2*DM_BITS-1:0]           wmask,
   output logic [pair_width(DQ_BITS)-1:0] rdata,
   output logic                           rvalid,
   output logic                           wactive,
   output logic [7:0]                     open_banks,
   output logic                           err,
   output logic [2:0]                     err_code
);

   localparam int unsigned PW    = pair_width(DQ_BITS);
   localparam int unsigned LANES = 2 * DM_BITS;
   localparam int unsigned BW    = DQ_BITS / DM_BITS;
   localparam int unsigned AW    = 3 + ROW_KEEP + COL_BITS + 2;
   localparam int unsigned XW    = 1 + 3 + ROW_KEEP + COL_BITS;

   typedef struct packed {
      logic                valid;
      logic [2:0]          bank;
      logic [ROW_KEEP-1:0] row;
      logic [COL_BITS-1:0] col;
   } xfer_t;

   logic [7:0]          open_q;
   logic [ROW_KEEP-1:0] row_q [8];
   logic [2:0]          ccd_q;
   err_e                err_q;
   err_e                new_err;
   cmd_e                cmd;
   logic                do_act, do_pre, do_rd, do_wr;

   always_comb begin
      cmd     = cmd_e'({RAS_N, CAS_N, WE_N});
      new_err = ERR_NONE;
      do_act  = 1'b0;
      do_pre  = 1'b0;
      do_rd   = 1'b0;
      do_wr   = 1'b0;
      if (CKE && !CS_N) begin
         unique case (cmd)
            CMD_ACT: if (open_q[BA]) new_err = ERR_ACT_OPEN; else do_act = 1'b1;
            CMD_RD, CMD_WR: begin
               if (!open_q[BA])        new_err = ERR_CLOSED;
               else if (ccd_q < TCCD)  new_err = ERR_TCCD;
               else begin
                  do_rd = (cmd == CMD_RD);
                  do_wr = (cmd == CMD_WR);
               end
            end
            CMD_PRE: do_pre = 1'b1;
            CMD_REF: if (|open_q) new_err = ERR_REF_OPEN;
            CMD_MRS: if (|open_q) new_err = ERR_MRS_OPEN;
            default: ;
         endcase
      end
   end

   // Bank table, tCCD counter and first-error latch; dropped commands only set the error
   always_ff @(posedge clk) begin
      if (rst) begin
         open_q <= '0;
         ccd_q  <= TCCD;
         err_q  <= ERR_NONE;
      end else begin
         if (do_act) open_q[BA] <= 1'b1;
         if (do_pre) begin
            if (ADDR[10]) open_q <= '0;
            else          open_q[BA] <= 1'b0;
         end
         if ((do_rd || do_wr) && ADDR[10]) open_q[BA] <= 1'b0;
         if (do_rd || do_wr)     ccd_q <= 3'd1;
         else if (ccd_q != TCCD) ccd_q <= ccd_q + 3'd1;
         if (err_q == ERR_NONE && new_err != ERR_NONE) err_q <= new_err;
      end
   end

   always_ff @(posedge clk) begin
      if (do_act) row_q[BA] <= ADDR[ROW_KEEP-1:0];
   end

   assign open_banks = open_q;
   assign err        = (err_q != ERR_NONE);
   assign err_code   = err_q;

   xfer_t rd_in, wr_in, rd_dl, wr_dl;

   assign rd_in = '{valid: do_rd, bank: BA, row: row_q[BA], col: ADDR[9:3]};
   assign wr_in = '{valid: do_wr, bank: BA, row: row_q[BA], col: ADDR[9:3]};

   // CL-1 stages: the last edge of delay issues the RAM read, the output register adds one more
   ddr3_delay_line #(.DEPTH(CL - 1), .WIDTH(XW)) u_rd_dl (
      .clk  (clk),
      .rst  (rst),
      .din  (rd_in),
      .dout (rd_dl)
   );

   ddr3_delay_line #(.DEPTH(CWL), .WIDTH(XW)) u_wr_dl (
      .clk  (clk),
      .rst  (rst),
      .din  (wr_in),
      .dout (wr_dl)
   );

   logic [PW-1:0] mem [2**AW];
   logic [PW-1:0] ram_q;
   logic          ram_v;

   xfer_t         rd_hold, wr_hold;
   logic [1:0]    rd_pair, wr_pair;
   logic          rd_busy, wr_busy;
   logic          rd_go, wr_go;
   logic [AW-1:0] raddr, waddr;

   always_comb begin
      rd_go = rd_dl.valid || rd_busy;
      wr_go = (wr_dl.valid || wr_busy) && !rst;
      if (rd_dl.valid) raddr = {rd_dl.bank, rd_dl.row, rd_dl.col, 2'd0};
      else             raddr = {rd_hold.bank, rd_hold.row, rd_hold.col, rd_pair};
      if (wr_dl.valid) waddr = {wr_dl.bank, wr_dl.row, wr_dl.col, 2'd0};
      else             waddr = {wr_hold.bank, wr_hold.row, wr_hold.col, wr_pair};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_hold <= '0;
         rd_pair <= '0;
         rd_busy <= 1'b0;
         ram_v   <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= '0;
         wr_hold <= '0;
         wr_pair <= '0;
         wr_busy <= 1'b0;
         wactive <= 1'b0;
      end else begin
         if (rd_dl.valid) begin
            rd_hold <= rd_dl;
            rd_pair <= 2'd1;
            rd_busy <= 1'b1;
         end else if (rd_busy) begin
            rd_pair <= rd_pair + 2'd1;
            rd_busy <= (rd_pair != 2'd3);
         end
         ram_v  <= rd_go;
         rvalid <= ram_v;
         if (ram_v) rdata <= ram_q;

         if (wr_dl.valid) begin
            wr_hold <= wr_dl;
            wr_pair <= 2'd1;
            wr_busy <= 1'b1;
         end else if (wr_busy) begin
            wr_pair <= wr_pair + 2'd1;
            wr_busy <= (wr_pair != 2'd3);
         end
         wactive <= wr_go;
      end
   end

   // Read-first: a write committed on the same edge is not visible to this read
   always_ff @(posedge clk) begin
      if (rd_go) ram_q <= mem[raddr];
   end

   always_ff @(posedge clk) begin
      if (wr_go) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (!wmask[i]) mem[waddr][i*BW +: BW] <= wdata[i*BW +: BW];
         end
      end
   end

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Directed bench for ddr3_cmd_responder: a command/status vector table plus
// cycle-indexed burst sequences with hand-computed data and timing.
module tb_ddr3_cmd_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        CKE, CS_N, RAS_N, CAS_N, WE_N;
   logic [2:0]  BA;
   logic [13:0] ADDR;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic [31:0] rdata;
   logic        rvalid, wactive, err;
   logic [7:0]  open_banks;
   logic [2:0]  err_code;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                          C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;

   always #5 clk = ~clk;

   ddr3_cmd_responder #(.CL(6), .CWL(5), .DQ_BITS(16), .DM_BITS(2), .ROW_KEEP(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .CKE        (CKE),
      .CS_N       (CS_N),
      .RAS_N      (RAS_N),
      .CAS_N      (CAS_N),
      .WE_N       (WE_N),
      .BA         (BA),
      .ADDR       (ADDR),
      .wdata      (wdata),
      .wmask      (wmask),
      .rdata      (rdata),
      .rvalid     (rvalid),
      .wactive    (wactive),
      .open_banks (open_banks),
      .err        (err),
      .err_code   (err_code)
   );

   typedef struct {
      logic        rst;
      logic        cke;
      logic        cs_n;
      logic [2:0]  cmd;
      logic [2:0]  ba;
      logic [13:0] addr;
      logic [7:0]  e_open;
      logic        e_err;
      logic [2:0]  e_code;
   } vec_t;

   vec_t vt [34];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic cmd(input logic [2:0] c, input logic [2:0] ba, input logic [13:0] a);
      CKE = 1'b1;
      CS_N = 1'b0;
      {RAS_N, CAS_N, WE_N} = c;
      BA = ba;
      ADDR = a;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cmd(C_NOP, 3'd0, 14'd0);
      tick();
      rst = 1'b0;
   endtask

   logic [31:0] pa [4];
   logic [31:0] pq [4];
   logic [31:0] pr [4];
   logic [31:0] pm [4];
   logic [31:0] ps [4];
   logic [31:0] pt [4];

   initial begin
      rst = 1'b1;
      cmd(C_NOP, 3'd0, 14'd0);
      wdata = '0;
      wmask = '0;

      pa = '{32'h11110000, 32'h33332222, 32'h55554444, 32'h77776666};
      pq = '{32'hA1A2A3A4, 32'hC1C2C3C4, 32'hD1D2D3D4, 32'hE1E2E3E4};
      pr = '{32'hB1B2B3B4, 32'h99999999, 32'h88888888, 32'h77777777};
      pm = '{32'hB1A2B3A4, 32'hC1C2C3C4, 32'hD1D2D3D4, 32'hE1E2E3E4};
      ps = '{32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};
      pt = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004};

      //        rst  cke  csn  cmd    ba    addr      open    err  code
      vt[0]  = '{1'b1, 1'b1, 1'b0, C_NOP, 3'd0, 14'h000, 8'h00, 1'b0, 3'd0};
      vt[1]  = '{1'b0, 1'b1, 1'b0, C_ACT, 3'd0, 14'h005, 8'h01, 1'b0, 3'd0};
      vt[2]  = '{1'b0, 1'b1, 1'b0, C_ACT, 3'd2, 14'h123, 8'h05, 1'b0, 3'd0};
      vt[3]  = '{1'b0, 1'b1, 1'b1, C_ACT, 3'd1, 14'h000, 8'h05, 1'b0, 3'd0};
      vt[4]  = '{1'b0, 1'b0, 1'b0, C_ACT, 3'd1, 14'h000, 8'h05, 1'b0, 3'd0};
      vt[5]  = '{1'b0, 1'b1, 1'b0, C_NOP, 3'd1, 14'h000, 8'h05, 1'b0, 3'd0};
      vt[6]  = '{1'b0, 1'b1, 1'b0, C_PRE, 3'd0, 14'h000, 8'h04, 1'b0, 3'd0};
      vt[7]  = '{1'b0, 1'b1, 1'b0, C_PRE, 3'd0, 14'h000, 8'h04, 1'b0, 3'd0};
      vt[8]  = '{1'b0, 1'b1, 1'b0, C_ACT, 3'd7, 14'h3FF, 8'h84, 1'b0, 3'd0};
      vt[9]  = '{1'b0, 1'b1, 1'b0, C_PRE, 3'd3, 14'h400, 8'h00, 1'b0, 3'd0};
      vt[10] = '{1'b0, 1'b1, 1'b0, C_REF, 3'd0, 14'h000, 8'h00, 1'b0, 3'd0};
      vt[11] = '{1'b0, 1'b1, 1'b0, C_MRS, 3'd0, 14'h000, 8'h00, 1'b0, 3'd0};
      vt[12] = '{1'b0, 1'b1, 1'b0, C_ACT, 3'd1, 14'h000, 8'h02, 1'b0, 3'd0};
      vt[13] = '{1'b0, 1'b1, 1'b0, C_ACT, 3'd1, 14'h001, 8'h02, 1'b1, 3'd1};
      vt[14] = '{1'b0, 1'b1, 1'b0, C_PRE, 3'd1, 14'h000, 8'h00, 1'b1, 3'd1};
      vt[15] = '{1'b0, 1'b1, 1'b0, C_ACT, 3'd0, 14'h000, 8'h01, 1'b1, 3'd1};
      vt[16] = '{1'b0, 1'b1, 1'b0, C_REF, 3'd0, 14'h000, 8'h01, 1'b1, 3'd1};
      vt[17] = '{1'b1, 1'b1, 1'b0, C_NOP, 3'd0, 14'h000, 8'h00, 1'b0, 3'd0};
      vt[18] = '{1'b0, 1'b1, 1'b0, C_ACT, 3'd4, 14'h000, 8'h10, 1'b0, 3'd0};
      vt[19] = '{1'b0, 1'b1, 1'b0, C_REF, 3'd0, 14'h000, 8'h10, 1'b1, 3'd3};
      vt[20] = '{1'b1, 1'b1, 1'b0, C_NOP, 3'd0, 14'h000, 8'h00, 1'b0, 3'd0};
      vt[21] = '{1'b0, 1'b1, 1'b0, C_ACT, 3'd4, 14'h000, 8'h10, 1'b0, 3'd0};
      vt[22] = '{1'b0, 1'b1, 1'b0, C_MRS, 3'd0, 14'h000, 8'h10, 1'b1, 3'd5};
      vt[23] = '{1'b1, 1'b1, 1'b0, C_NOP, 3'd0, 14'h000, 8'h00, 1'b0, 3'd0};
      vt[24] = '{1'b0, 1'b1, 1'b0, C_RD,  3'd6, 14'h000, 8'h00, 1'b1, 3'd2};
      vt[25] = '{1'b1, 1'b1, 1'b0, C_NOP, 3'd0, 14'h000, 8'h00, 1'b0, 3'd0};
      vt[26] = '{1'b0, 1'b1, 1'b0, C_ACT, 3'd2, 14'h000, 8'h04, 1'b0, 3'd0};
      vt[27] = '{1'b0, 1'b1, 1'b0, C_NOP, 3'd0, 14'h000, 8'h04, 1'b0, 3'd0};
      vt[28] = '{1'b0, 1'b1, 1'b0, C_NOP, 3'd0, 14'h000, 8'h04, 1'b0, 3'd0};
      vt[29] = '{1'b0, 1'b1, 1'b0, C_NOP, 3'd0, 14'h000, 8'h04, 1'b0, 3'd0};
      vt[30] = '{1'b0, 1'b1, 1'b0, C_RD,  3'd2, 14'h400, 8'h00, 1'b0, 3'd0};
      vt[31] = '{1'b0, 1'b1, 1'b0, C_ACT, 3'd2, 14'h000, 8'h04, 1'b0, 3'd0};
      vt[32] = '{1'b0, 1'b1, 1'b0, C_WR,  3'd2, 14'h400, 8'h04, 1'b1, 3'd4};
      vt[33] = '{1'b1, 1'b1, 1'b0, C_NOP, 3'd0, 14'h000, 8'h00, 1'b0, 3'd0};

      for (int i = 0; i < 34; i++) begin
         rst  = vt[i].rst;
         CKE  = vt[i].cke;
         CS_N = vt[i].cs_n;
         {RAS_N, CAS_N, WE_N} = vt[i].cmd;
         BA   = vt[i].ba;
         ADDR = vt[i].addr;
         tick();
         check($sformatf("vec%0d open_banks", i), 32'(open_banks), 32'(vt[i].e_open));
         check($sformatf("vec%0d err", i), 32'(err), 32'(vt[i].e_err));
         check($sformatf("vec%0d err_code", i), 32'(err_code), 32'(vt[i].e_code));
         if (vt[i].rst) begin
            check($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'd0);
            check($sformatf("vec%0d wactive", i), 32'(wactive), 32'd0);
            check($sformatf("vec%0d rdata", i), rdata, 32'd0);
         end
      end
      rst = 1'b0;

      // Write with auto-precharge, re-open, read back after CL
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         case (c)
            1:       cmd(C_ACT, 3'd0, 14'd5);
            5:       cmd(C_WR,  3'd0, 14'h400);
            6:       cmd(C_ACT, 3'd0, 14'd5);
            9:       cmd(C_RD,  3'd0, 14'h000);
            default: cmd(C_NOP, 3'd0, 14'd0);
         endcase
         wmask = '0;
         wdata = (c >= 10 && c <= 13) ? pa[c-10] : 32'hDEAD0000 + 32'(c);
         tick();
         check($sformatf("A c%0d wactive", c), 32'(wactive), 32'(c >= 10 && c <= 13));
         check($sformatf("A c%0d rvalid", c), 32'(rvalid), 32'(c >= 15 && c <= 18));
         if (c >= 15 && c <= 18) check($sformatf("A c%0d rdata", c), rdata, pa[c-15]);
         if (c == 5) check("A autopre open_banks", 32'(open_banks), 32'h00);
         if (c == 6) check("A reopen open_banks", 32'(open_banks), 32'h01);
      end
      check("A err", 32'(err), 32'd0);

      // Masked overwrite, then two seamless reads 4 cycles apart
      for (int c = 1; c <= 24; c++) begin
         case (c)
            1:       cmd(C_WR, 3'd0, 14'h008);
            5:       cmd(C_WR, 3'd0, 14'h008);
            9:       cmd(C_RD, 3'd0, 14'h000);
            13:      cmd(C_RD, 3'd0, 14'h00F);
            default: cmd(C_NOP, 3'd0, 14'd0);
         endcase
         if (c >= 6 && c <= 9) begin
            wdata = pq[c-6];
            wmask = 4'h0;
         end else if (c >= 10 && c <= 13) begin
            wdata = pr[c-10];
            wmask = (c == 10) ? 4'b0101 : 4'hF;
         end else begin
            wdata = 32'hBEEF0000 + 32'(c);
            wmask = 4'h0;
         end
         tick();
         check($sformatf("B c%0d wactive", c), 32'(wactive), 32'(c >= 6 && c <= 13));
         check($sformatf("B c%0d rvalid", c), 32'(rvalid), 32'(c >= 15 && c <= 22));
         if (c >= 15 && c <= 18) check($sformatf("B c%0d rdata", c), rdata, pa[c-15]);
         if (c >= 19 && c <= 22) check($sformatf("B c%0d rdata", c), rdata, pm[c-19]);
      end
      check("B err", 32'(err), 32'd0);

      // Read to a closed bank is dropped; later traffic still works
      do_reset();
      for (int c = 1; c <= 21; c++) begin
         case (c)
            1:       cmd(C_RD,  3'd3, 14'h000);
            2:       cmd(C_ACT, 3'd3, 14'h3FFE);
            6:       cmd(C_WR,  3'd3, 14'h000);
            10:      cmd(C_RD,  3'd3, 14'h000);
            default: cmd(C_NOP, 3'd0, 14'd0);
         endcase
         wmask = '0;
         wdata = (c >= 11 && c <= 14) ? ps[c-11] : 32'h5A5A0000 + 32'(c);
         tick();
         if (c == 1) check("C closed err_code", 32'(err_code), 32'd2);
         if (c == 2) check("C act open_banks", 32'(open_banks), 32'h08);
         check($sformatf("C c%0d rvalid", c), 32'(rvalid), 32'(c >= 16 && c <= 19));
         if (c >= 16 && c <= 19) check($sformatf("C c%0d rdata", c), rdata, ps[c-16]);
      end
      check("C err sticky", 32'(err), 32'd1);
      check("C err_code sticky", 32'(err_code), 32'd2);

      // tCCD violation drops the write; then reset aborts a read burst
      do_reset();
      for (int c = 1; c <= 34; c++) begin
         case (c)
            1:       cmd(C_ACT, 3'd1, 14'h000);
            5:       cmd(C_WR,  3'd1, 14'h000);
            9:       cmd(C_RD,  3'd1, 14'h000);
            11:      cmd(C_WR,  3'd1, 14'h000);
            21:      cmd(C_RD,  3'd1, 14'h000);
            30:      cmd(C_MRS, 3'd0, 14'h000);
            default: cmd(C_NOP, 3'd0, 14'd0);
         endcase
         rst   = (c == 28);
         wmask = '0;
         wdata = (c >= 10 && c <= 13) ? pt[c-10] : 32'h0D0D0000 + 32'(c);
         tick();
         if (c <= 20) begin
            check($sformatf("D c%0d wactive", c), 32'(wactive), 32'(c >= 10 && c <= 13));
            check($sformatf("D c%0d rvalid", c), 32'(rvalid), 32'(c >= 15 && c <= 18));
            if (c >= 15 && c <= 18) check($sformatf("D c%0d rdata", c), rdata, pt[c-15]);
         end
         if (c == 11) check("D tccd err_code", 32'(err_code), 32'd4);
         if (c == 27) begin
            check("E first rvalid", 32'(rvalid), 32'd1);
            check("E first rdata", rdata, pt[0]);
         end
         if (c == 28) begin
            check("E rst rvalid", 32'(rvalid), 32'd0);
            check("E rst wactive", 32'(wactive), 32'd0);
            check("E rst rdata", rdata, 32'd0);
            check("E rst open_banks", 32'(open_banks), 32'd0);
            check("E rst err", 32'(err), 32'd0);
            check("E rst err_code", 32'(err_code), 32'd0);
         end
         if (c > 28) check($sformatf("E c%0d rvalid", c), 32'(rvalid), 32'd0);
      end
      check("E mrs err", 32'(err), 32'd0);
      check("E mrs err_code", 32'(err_code), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
